// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_core multi-cycle CPU: opcodes, FSM states and
// instruction field positions.
package cpu_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_LOAD  = 3'b100;
  localparam logic [2:0] OP_STORE = 3'b101;

  typedef enum logic [1:0] {FETCH, EXEC, MEM} state_e;

  // rd and rt share one field, as do rs1 and base
  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 13;
  localparam int unsigned RD_MSB  = 12;
  localparam int unsigned RD_LSB  = 11;
  localparam int unsigned RS1_MSB = 10;
  localparam int unsigned RS1_LSB = 9;
  localparam int unsigned RS2_MSB = 8;
  localparam int unsigned RS2_LSB = 7;
  localparam int unsigned IMM_MSB = 8;

endpackage

// File: rtl/cpu_core_ram.sv
// Unified program/data RAM: combinational read, synchronous write, no reset.
module cpu_core_ram #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned Depth     = 256
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] addr_i,
  input  logic [DataWidth-1:0]     wdata_i,
  output logic [DataWidth-1:0]     rdata_o
);

  logic [DataWidth-1:0] mem [0:Depth-1];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/cpu_core_regfile.sv
// Four-entry register file: two combinational read ports, one synchronous write port.
module cpu_core_regfile #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [1:0]       waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [1:0]       raddr_a_i,
  input  logic [1:0]       raddr_b_i,
  output logic [Width-1:0] rdata_a_o,
  output logic [Width-1:0] rdata_b_o
);

  logic [Width-1:0] regs [4];

  reg16 #(.Width(Width)) x0 (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .we_i  (we_i && (waddr_i == 2'd0)),
    .d_i   (wdata_i),
    .q_o   (regs[0])
  );

  reg16 #(.Width(Width)) x1 (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .we_i  (we_i && (waddr_i == 2'd1)),
    .d_i   (wdata_i),
    .q_o   (regs[1])
  );

  reg16 #(.Width(Width)) x2 (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .we_i  (we_i && (waddr_i == 2'd2)),
    .d_i   (wdata_i),
    .q_o   (regs[2])
  );

  reg16 #(.Width(Width)) x3 (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .we_i  (we_i && (waddr_i == 2'd3)),
    .d_i   (wdata_i),
    .q_o   (regs[3])
  );

  assign rdata_a_o = regs[raddr_a_i];
  assign rdata_b_o = regs[raddr_b_i];

endmodule

// File: rtl/reg16.sv
// Single register with asynchronous active-low reset and write enable.
module reg16 #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q <= '0;
    end else if (we_i) begin
      q <= d_i;
    end
  end

  assign q_o = q;

endmodule

// File: rtl/cpu_core.sv
// Minimal 16-bit multi-cycle von Neumann CPU: FETCH -> EXEC [-> MEM] with ADD, SUB,
// LOAD, STORE and NOP, four registers and one 256-word unified RAM.
module cpu_core #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input logic clk,
  input logic rst
);

  import cpu_pkg::*;

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] ir_q;
  logic [7:0]            ea_q;
  state_e                state_q;

  logic [2:0]            op;
  logic                  is_nop, is_rtype, is_mem;
  logic [DATA_WIDTH-1:0] rf_a, rf_b, alu_res, ram_rdata, rf_wdata;
  logic [1:0]            rf_raddr_b;
  logic                  rf_we, ram_we;
  logic [7:0]            ram_addr, ea_d;

  assign op       = ir_q[OP_MSB:OP_LSB];
  assign is_nop   = (ir_q == '0);
  assign is_rtype = !is_nop && ((op == OP_ADD) || (op == OP_SUB));
  assign is_mem   = (op == OP_LOAD) || (op == OP_STORE);

  // Port B reads rt for memory ops (store data), rs2 otherwise
  assign rf_raddr_b = is_mem ? ir_q[RD_MSB:RD_LSB] : ir_q[RS2_MSB:RS2_LSB];
  assign alu_res    = (op == OP_SUB) ? (rf_a - rf_b) : (rf_a + rf_b);

  // RAM only decodes the low byte of EA, and sign extension never reaches it
  assign ea_d = rf_a[7:0] + ir_q[IMM_MSB-1:0];

  assign ram_addr = (state_q == MEM) ? ea_q : pc_q[7:0];
  assign ram_we   = (state_q == MEM) && (op == OP_STORE);

  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = alu_res;
    if ((state_q == EXEC) && is_rtype) begin
      rf_we = 1'b1;
    end else if ((state_q == MEM) && (op == OP_LOAD)) begin
      rf_we    = 1'b1;
      rf_wdata = ram_rdata;
    end
  end

  cpu_core_ram #(
    .DataWidth(DATA_WIDTH),
    .Depth    (256)
  ) ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(rf_b),
    .rdata_o(ram_rdata)
  );

  cpu_core_regfile #(
    .Width(DATA_WIDTH)
  ) RF (
    .clk_i    (clk),
    .rst_ni   (rst),
    .we_i     (rf_we),
    .waddr_i  (ir_q[RD_MSB:RD_LSB]),
    .wdata_i  (rf_wdata),
    .raddr_a_i(ir_q[RS1_MSB:RS1_LSB]),
    .raddr_b_i(rf_raddr_b),
    .rdata_a_o(rf_a),
    .rdata_b_o(rf_b)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= '0;
      ir_q    <= '0;
      ea_q    <= '0;
      state_q <= FETCH;
    end else begin
      unique case (state_q)
        FETCH: begin
          ir_q    <= ram_rdata;
          pc_q    <= pc_q + 1'b1;
          state_q <= EXEC;
        end
        EXEC: begin
          if (is_mem) begin
            ea_q    <= ea_d;
            state_q <= MEM;
          end else begin
            state_q <= FETCH;
          end
        end
        MEM:     state_q <= FETCH;
        default: state_q <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: directed programs plus random programs checked
// against an instruction-level reference model.
module tb_cpu_core;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cpu_core dut (
    .clk(clk),
    .rst(rst)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_mem [256];
  logic [15:0] m_r   [4];
  logic [15:0] m_pc;

  function automatic logic [15:0] enc_r(logic [2:0] op, logic [1:0] rd, logic [1:0] rs1,
                                        logic [1:0] rs2);
    return {op, rd, rs1, rs2, 7'b0};
  endfunction

  function automatic logic [15:0] enc_m(logic [2:0] op, logic [1:0] rt, logic [1:0] base,
                                        logic [8:0] imm);
    return {op, rt, base, imm};
  endfunction

  function automatic logic [15:0] dut_reg(int i);
    case (i)
      0:       return dut.RF.x0.q;
      1:       return dut.RF.x1.q;
      2:       return dut.RF.x2.q;
      default: return dut.RF.x3.q;
    endcase
  endfunction

  // Instruction-set reference: executes one instruction, returns its cycle cost
  function automatic int model_step();
    logic [15:0] ir, ea;
    ir   = m_mem[m_pc[7:0]];
    m_pc = m_pc + 16'd1;
    if (ir == 16'h0000) return 2;
    ea = m_r[ir[10:9]] + {{7{ir[8]}}, ir[8:0]};
    case (ir[15:13])
      3'b000: begin m_r[ir[12:11]] = m_r[ir[10:9]] + m_r[ir[8:7]]; return 2; end
      3'b001: begin m_r[ir[12:11]] = m_r[ir[10:9]] - m_r[ir[8:7]]; return 2; end
      3'b100: begin m_r[ir[12:11]] = m_mem[ea[7:0]]; return 3; end
      3'b101: begin m_mem[ea[7:0]] = m_r[ir[12:11]]; return 3; end
      default: return 2;
    endcase
  endfunction

  task automatic poke(int a, logic [15:0] v);
    dut.ram.mem[a] = v;
    m_mem[a]       = v;
  endtask

  task automatic start();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 256; i++) poke(i, 16'h0000);
    poke(100, 16'd5);
    poke(101, 16'd7);
    for (int r = 0; r < 4; r++) m_r[r] = 16'h0000;
    m_pc = 16'h0000;
  endtask

  task automatic go();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_main_prog();
    poke(3,  enc_m(OP_LOAD, 2'd1, 2'd0, 9'd100));
    poke(4,  enc_m(OP_LOAD, 2'd2, 2'd0, 9'd101));
    poke(5,  enc_r(OP_ADD, 2'd3, 2'd1, 2'd2));
    poke(6,  enc_r(OP_SUB, 2'd0, 2'd2, 2'd1));
    poke(7,  enc_m(OP_STORE, 2'd3, 2'd3, 9'd100));
    poke(8,  enc_m(OP_LOAD, 2'd1, 2'd3, 9'd100));
    poke(9,  enc_r(OP_SUB, 2'd2, 2'd1, 2'd0));
    poke(10, 16'h0000);
    poke(11, enc_r(OP_ADD, 2'd3, 2'd2, 2'd0));
  endtask

  task automatic test_reset();
    start();
    n_checks++;
    if (dut.pc_q !== 16'h0000) begin
      n_fail++; $display("FAIL reset_pc: got %h want 0000", dut.pc_q);
    end
    n_checks++;
    if (dut.ir_q !== 16'h0000) begin
      n_fail++; $display("FAIL reset_ir: got %h want 0000", dut.ir_q);
    end
    n_checks++;
    if (dut.state_q !== FETCH) begin
      n_fail++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, FETCH);
    end
    for (int r = 0; r < 4; r++) begin
      n_checks++;
      if (dut_reg(r) !== 16'h0000) begin
        n_fail++; $display("FAIL reset_R%0d: got %h want 0000", r, dut_reg(r));
      end
    end
  endtask

  task automatic test_program();
    logic [15:0] exp_r [4];
    exp_r = '{16'd2, 16'd12, 16'd10, 16'd12};
    start();
    load_main_prog();
    go();
    run(150);
    for (int r = 0; r < 4; r++) begin
      n_checks++;
      if (dut_reg(r) !== exp_r[r]) begin
        n_fail++; $display("FAIL prog_R%0d: got %h want %h", r, dut_reg(r), exp_r[r]);
      end
    end
    n_checks++;
    if (dut.ram.mem[100] !== 16'd5 || dut.ram.mem[101] !== 16'd7) begin
      n_fail++;
      $display("FAIL prog_data: got %h/%h want 0005/0007", dut.ram.mem[100], dut.ram.mem[101]);
    end
    n_checks++;
    if (dut.ram.mem[112] !== 16'd12) begin
      n_fail++; $display("FAIL prog_mem112: got %h want 000c", dut.ram.mem[112]);
    end
    // 28 cycles reach PC=12, the remaining 122 are 61 zero-word NOPs
    n_checks++;
    if (dut.pc_q !== 16'd73) begin
      n_fail++; $display("FAIL prog_pc: got %0d want 73", dut.pc_q);
    end
  endtask

  task automatic test_nop();
    int cyc;
    int bad;
    start();
    load_main_prog();
    go();
    cyc = 0;
    while (cyc < 24) cyc += model_step();
    run(24);
    n_checks++;
    if (dut.pc_q !== 16'd10 || dut_reg(0) !== 16'd2) begin
      n_fail++; $display("FAIL nop_before: got pc=%0d R0=%h want pc=10 R0=0002",
                         dut.pc_q, dut_reg(0));
    end
    run(2);
    n_checks++;
    if (dut.pc_q !== 16'd11) begin
      n_fail++; $display("FAIL nop_pc: got %0d want 11", dut.pc_q);
    end
    n_checks++;
    if (dut_reg(0) !== 16'd2) begin
      n_fail++; $display("FAIL nop_R0: got %h want 0002", dut_reg(0));
    end
    bad = -1;
    for (int i = 0; i < 256; i++) if (bad < 0 && dut.ram.mem[i] !== m_mem[i]) bad = i;
    n_checks++;
    if (bad >= 0) begin
      n_fail++; $display("FAIL nop_ram: mem[%0d] got %h want %h", bad, dut.ram.mem[bad],
                         m_mem[bad]);
    end
  endtask

  task automatic test_wrap();
    start();
    poke(102, 16'hFFFF);
    poke(103, 16'h0001);
    poke(0, enc_m(OP_LOAD, 2'd1, 2'd0, 9'd102));
    poke(1, enc_m(OP_LOAD, 2'd2, 2'd0, 9'd103));
    poke(2, enc_r(OP_ADD, 2'd3, 2'd1, 2'd2));
    poke(3, enc_r(OP_SUB, 2'd0, 2'd3, 2'd2));
    go();
    run(10);
    n_checks++;
    if (dut_reg(3) !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_add: got %h want 0000", dut_reg(3));
    end
    n_checks++;
    if (dut_reg(0) !== 16'hFFFF) begin
      n_fail++; $display("FAIL wrap_sub: got %h want ffff", dut_reg(0));
    end
  endtask

  task automatic test_neg_offset();
    start();
    poke(104, 16'd110);
    poke(0, enc_m(OP_LOAD, 2'd1, 2'd0, 9'd104));
    poke(1, enc_m(OP_LOAD, 2'd2, 2'd1, 9'h1F6));
    go();
    run(6);
    n_checks++;
    if (dut_reg(2) !== 16'd5) begin
      n_fail++; $display("FAIL neg_offset: got %h want 0005", dut_reg(2));
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] first;
    start();
    first = enc_m(OP_LOAD, 2'd1, 2'd0, 9'd100);
    poke(0, first);
    poke(1, enc_m(OP_LOAD, 2'd2, 2'd0, 9'd101));
    go();
    run(5);
    n_checks++;
    if (dut.state_q !== MEM || dut_reg(1) !== 16'd5 || dut.pc_q !== 16'd2) begin
      n_fail++; $display("FAIL rstmid_pre: got state=%0d R1=%h pc=%0d want 2/0005/2",
                         dut.state_q, dut_reg(1), dut.pc_q);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (dut_reg(1) !== 16'h0000 || dut.pc_q !== 16'h0000 || dut.state_q !== FETCH) begin
      n_fail++; $display("FAIL rstmid_async: got R1=%h pc=%0d state=%0d want 0000/0/0",
                         dut_reg(1), dut.pc_q, dut.state_q);
    end
    run(2);
    n_checks++;
    if (dut_reg(2) !== 16'h0000) begin
      n_fail++; $display("FAIL rstmid_abort: got R2=%h want 0000", dut_reg(2));
    end
    go();
    run(1);
    n_checks++;
    if (dut.pc_q !== 16'd1 || dut.ir_q !== first) begin
      n_fail++; $display("FAIL rstmid_refetch: got pc=%0d ir=%h want 1/%h",
                         dut.pc_q, dut.ir_q, first);
    end
    run(2);
    n_checks++;
    if (dut_reg(1) !== 16'd5) begin
      n_fail++; $display("FAIL rstmid_rerun: got R1=%h want 0005", dut_reg(1));
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] val;
    start();
    val = 16'($urandom);
    poke(105, val);
    poke(0, enc_m(OP_LOAD, 2'd1, 2'd0, 9'd105));
    poke(1, enc_m(OP_STORE, 2'd1, 2'd0, 9'd120));
    poke(2, enc_m(OP_LOAD, 2'd2, 2'd0, 9'd120));
    go();
    run(6);
    n_checks++;
    if (dut.ram.mem[120] !== val) begin
      n_fail++; $display("FAIL b2b_store: got %h want %h", dut.ram.mem[120], val);
    end
    run(3);
    n_checks++;
    if (dut_reg(2) !== val) begin
      n_fail++; $display("FAIL b2b_load: got %h want %h", dut_reg(2), val);
    end
  endtask

  task automatic test_random();
    int cyc;
    int bad;
    int kind;
    logic [15:0] ins;
    logic [2:0] rop;
    logic [2:0] rsv [4];
    rsv = '{3'b010, 3'b011, 3'b110, 3'b111};
    for (int it = 0; it < 6; it++) begin
      start();
      for (int a = 128; a < 256; a++) poke(a, 16'($urandom));
      for (int a = 0; a < 40; a++) begin
        kind = int'($urandom_range(0, 5));
        case (kind)
          0: ins = enc_r(OP_ADD, 2'($urandom), 2'($urandom), 2'($urandom));
          1: ins = enc_r(OP_SUB, 2'($urandom), 2'($urandom), 2'($urandom));
          2: ins = enc_m(OP_LOAD, 2'($urandom), 2'($urandom), 9'($urandom));
          3: ins = enc_m(OP_STORE, 2'($urandom), 2'($urandom), 9'($urandom));
          4: ins = 16'h0000;
          default: begin
            rop = rsv[$urandom_range(0, 3)];
            ins = {rop, 13'($urandom)};
          end
        endcase
        poke(a, ins);
      end
      go();
      cyc = 0;
      for (int k = 0; k < 40; k++) cyc += model_step();
      run(cyc);
      for (int r = 0; r < 4; r++) begin
        n_checks++;
        if (dut_reg(r) !== m_r[r]) begin
          n_fail++; $display("FAIL rand%0d_R%0d: got %h want %h", it, r, dut_reg(r), m_r[r]);
        end
      end
      n_checks++;
      if (dut.pc_q !== m_pc) begin
        n_fail++; $display("FAIL rand%0d_pc: got %0d want %0d", it, dut.pc_q, m_pc);
      end
      bad = -1;
      for (int i = 0; i < 256; i++) if (bad < 0 && dut.ram.mem[i] !== m_mem[i]) bad = i;
      n_checks++;
      if (bad >= 0) begin
        n_fail++; $display("FAIL rand%0d_mem[%0d]: got %h want %h", it, bad,
                           dut.ram.mem[bad], m_mem[bad]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_nop();
    test_wrap();
    test_neg_offset();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
